spi_sample_rx: RTL and testbench



---
 rtl/spi_sample_rx_pkg.sv | 23 ++
 rtl/spi_sample_rx_fifo.sv | 58 +++++
 rtl/spi_sample_rx.sv | 138 +++++++++++++
 tb/tb_spi_sample_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_sample_rx_pkg.sv
// Shared types for the FPGA-to-Pi sample link: sample word types, receiver states
// and the sign-magnitude to two's complement conversion reused by the TX side.
package fx_pkg;

    localparam int SAMPLE_W = 11;

    typedef logic [SAMPLE_W-1:0] sample_sm_t;
    typedef logic [SAMPLE_W-1:0] sample_tc_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } rx_state_t;

    // Negative zero falls out as zero because -0 == 0 in two's complement.
    function automatic sample_tc_t sm_to_tc(input sample_sm_t sm);
        sample_tc_t mag_ext;
        mag_ext = {1'b0, sm[SAMPLE_W-2:0]};
        return sm[SAMPLE_W-1] ? -mag_ext : mag_ext;
    endfunction

endpackage

// File: rtl/spi_sample_rx_fifo.sv
// Small synchronous FIFO with push/pop/full/empty; a push into a full FIFO is
// accepted when a pop happens in the same cycle. Shared with the TX side.
module sample_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_sample_rx.sv
// SPI peripheral receiver: oversampled sign-magnitude frames into a sample FIFO.
// Define TWOS_COMP_EN to convert samples to two's complement; otherwise raw words pass through.
module spi_sample_rx
    import fx_pkg::*;
#(
    parameter int DATA_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              sdi,
    input  logic              ncs,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_err,
    output logic              overflow,
    output logic [15:0]       frame_count
);

    localparam int CNT_W = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

    logic sclk_s1, sclk_s2, sclk_s3;
    logic ncs_s1, ncs_s2, ncs_s3;
    logic sdi_s1, sdi_s2;
    logic sclk_rise, ncs_rise;

    rx_state_t         state, state_next;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic              push;
    logic [DATA_W-1:0] conv;

    logic pop, fifo_full, fifo_empty, accept, drop;

    // Synchronizers reset to the idle line levels so no false edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
            {ncs_s1, ncs_s2, ncs_s3}    <= 3'b111;
            {sdi_s1, sdi_s2}            <= 2'b00;
        end else begin
            {sclk_s1, sclk_s2, sclk_s3} <= {sclk, sclk_s1, sclk_s2};
            {ncs_s1, ncs_s2, ncs_s3}    <= {ncs, ncs_s1, ncs_s2};
            {sdi_s1, sdi_s2}            <= {sdi, sdi_s1};
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign ncs_rise  = ncs_s2 & ~ncs_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IDLE keys on the ncs level, so a fall that landed during DONE is still taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!ncs_s2) state_next = SHIFT;
            SHIFT:   if (ncs_rise) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        frame_err = 1'b0;
        if (state == DONE) begin
            if (bit_cnt == CNT_FULL) begin
                push = 1'b1;
            end else begin
                frame_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (state == SHIFT && sclk_rise && !ncs_rise) begin
            shift <= {shift[DATA_W-2:0], sdi_s2};
            if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TWOS_COMP_EN
    logic [DATA_W-1:0] mag_ext;
    assign mag_ext = {1'b0, shift[DATA_W-2:0]};
    assign conv    = shift[DATA_W-1] ? -mag_ext : mag_ext;
`else
    assign conv = shift;
`endif

    sample_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (conv),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign accept    = push & (~fifo_full | pop);
    assign drop      = push & fifo_full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            overflow    <= overflow | drop;
            frame_count <= frame_count + 16'(accept);
        end
    end

endmodule

// File: tb/tb_spi_sample_rx.sv
// Scoreboard bench for spi_sample_rx: frames are driven on the SPI pins, expected
// samples queued at send time and compared as the DUT pops them.
module tb_spi_sample_rx;

    localparam int HALF = 320;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        sdi;
    logic        ncs;
    logic        out_ready;
    logic        out_valid;
    logic [10:0] out_data;
    logic        frame_err;
    logic        overflow;
    logic [15:0] frame_count;

    int          errors = 0;
    int          checks = 0;
    int          err_pulses = 0;
    int          exp_errs = 0;
    int          exp_frames = 0;
    logic [10:0] exp_q[$];

    spi_sample_rx #(
        .DATA_W     (11),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .sdi         (sdi),
        .ncs         (ncs),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] expectedOf(input logic [10:0] w);
`ifdef TWOS_COMP_EN
        int mag;
        mag = int'(w[9:0]);
        if (w[10] && mag != 0) return 11'(2048 - mag);
        return 11'(mag);
`else
        return w;
`endif
    endfunction

    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) checkOutput("spurious_pop", {31'd0, out_valid}, 32'd0);
            else checkOutput("data", {21'd0, out_data}, {21'd0, exp_q.pop_front()});
        end
    end

    task automatic sendBits(input logic [15:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = word[i];
            #HALF sclk = 1'b1;
            #HALF sclk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit accept, input bit ready_in_done);
        @(posedge clk) #1 ncs = 1'b0;
        #HALF;
        sendBits(word, nbits);
        #HALF;
        @(posedge clk) #1 ncs = 1'b1;
        if (accept) begin
            exp_q.push_back(expectedOf(word[10:0]));
            exp_frames++;
        end
        if (nbits != 11) exp_errs++;
        if (ready_in_done) begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        checkOutput(tag, exp_q.size(), 0);
        @(negedge clk);
        checkOutput({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic resetDut();
        @(posedge clk) #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_frames = 0;
        exp_q.delete();
    endtask

    initial begin
        #900000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; sclk = 1'b0; sdi = 1'b0; ncs = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {21'd0, out_data}, 32'd0);
        checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk) #1 reset = 1'b0;

        $display("[TB] single negative frame");
        @(posedge clk) #1 out_ready = 1'b1;
        applyStimulus(16'h405, 11, 1'b1, 1'b0);
        waitDrain("drain_neg5");
        checkOutput("count_neg5", {16'd0, frame_count}, exp_frames);
        checkOutput("errs_neg5", err_pulses, exp_errs);

        $display("[TB] max magnitude and negative zero");
        applyStimulus(16'h3FF, 11, 1'b1, 1'b0);
        applyStimulus(16'h400, 11, 1'b1, 1'b0);
        waitDrain("drain_extremes");
        checkOutput("count_extremes", {16'd0, frame_count}, exp_frames);

        $display("[TB] short and long frames");
        applyStimulus(16'h155, 10, 1'b0, 1'b0);
        checkOutput("errs_short", err_pulses, exp_errs);
        applyStimulus(16'hABC, 12, 1'b0, 1'b0);
        checkOutput("errs_long", err_pulses, exp_errs);
        checkOutput("valid_bad_frames", {31'd0, out_valid}, 32'd0);
        checkOutput("count_bad_frames", {16'd0, frame_count}, exp_frames);

        $display("[TB] overflow with consumer stalled");
        @(posedge clk) #1 out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(16'(i), 11, (i <= 4), 1'b0);
        @(negedge clk);
        checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
        checkOutput("ovf_count", {16'd0, frame_count}, exp_frames);
        checkOutput("ovf_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("ovf_head", {21'd0, out_data}, {21'd0, exp_q[0]});
        repeat (5) @(negedge clk);
        checkOutput("ovf_head_stable", {21'd0, out_data}, {21'd0, exp_q[0]});
        @(posedge clk) #1 out_ready = 1'b1;
        waitDrain("drain_ovf");
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

        $display("[TB] pop in the push cycle of a full FIFO");
        resetDut();
        @(negedge clk);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
        @(posedge clk) #1 out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(16'(i), 11, 1'b1, 1'b0);
        applyStimulus(16'd5, 11, 1'b1, 1'b1);
        waitDrain("drain_same_cycle");
        checkOutput("same_cycle_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("same_cycle_count", {16'd0, frame_count}, exp_frames);

        $display("[TB] reset during a frame");
        @(posedge clk) #1 ncs = 1'b0;
        #HALF;
        sendBits(16'h2A, 6);
        resetDut();
        #HALF;
        sendBits(16'h15, 5);
        #HALF;
        @(posedge clk) #1 ncs = 1'b1;
        exp_errs++;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_errs", err_pulses, exp_errs);
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_count", {16'd0, frame_count}, 32'd0);
        applyStimulus(16'h00A, 11, 1'b1, 1'b0);
        waitDrain("drain_after_rst");
        checkOutput("count_after_rst", {16'd0, frame_count}, exp_frames);
        checkOutput("errs_final", err_pulses, exp_errs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
